alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single ALU between two requesters: port 0 = EX stage, port 1 = address/branch unit.
//  Round-robin grant, with one transaction in flight at a time.
//  Operands and op are held stable on the ALU for the whole transaction.
//  Result, zero and divide-by-zero status are returned to the granted requester over a valid/ready response.
// PARAMETERS
//  XLEN   32  operand/result width
//  OPW    5   ALU opcode width (encodings from cpu/defines.vh)
// PORTS
//  clk            in   1     clock; all logic on posedge
//  rst_n          in   1     reset; synchronous, active-low
//  req_valid      in   2     per-requester request valid, bit i = requester i
//  req_ready      out  2     per-requester request accepted
//  req_op         in   2*OPW packed opcodes, [i*OPW +: OPW]
//  req_a, req_b   in   2*XLEN packed operands
//  rsp_valid      out  2     per-requester response valid
//  rsp_ready      in   2     per-requester response accept
//  rsp_data       out  XLEN  result, shared bus, meaningful only with rsp_valid
//  rsp_zero       out  1     result == 0
//  rsp_err        out  1     DIV/DIVU/REM/REMU with b == 0
//  alu_op         out  OPW   to ALU
//  alu_a, alu_b   out  XLEN  to ALU
//  alu_res        in   XLEN  from ALU, combinational
//  alu_zero       in   1     from ALU, combinational
//  alu_illegal    in   1     from ALU, registered one cycle after inputs
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - state=IDLE, rr_last=1 (requester 0 wins first tie)
//   - all req_ready/rsp_valid 0; rsp_data/zero/err 0; alu_op=`ADD, alu_a=alu_b=0
//  FSM: IDLE -> EXEC -> [FLAG] -> RESP -> IDLE
//  IDLE
//   - req_ready asserted combinationally to the chosen requester only
//   - single valid wins; both valid -> requester != rr_last wins
//   - on handshake: latch op/a/b and grant id, rr_last<=id, go EXEC
//  EXEC
//   - latched regs drive alu_*; capture alu_res/alu_zero into rsp regs
//   - go FLAG (macro on) or RESP (off)
//  FLAG
//   - alu_* still held; capture alu_illegal into rsp_err; go RESP
//  RESP
//   - rsp_valid[id]=1 only; data/zero/err stable until rsp_ready[id]
//   - on accept -> IDLE; new request accepted no earlier than that IDLE cycle
//   - no bypass: at most one txn in flight
//  Latency: accept at cycle 0 -> rsp_valid at cycle 3 (macro on), cycle 2 (off); 0 back-pressure.
//  alu_* hold the last latched values in IDLE and RESP (no toggling).
//  req_ready is 0 in every non-IDLE state; requests held by callers are not lost.
//  rsp_ready on a non-granted port is ignored.
//  rsp_ready asserted before rsp_valid has no effect.
//  Opcode not recognised by ALU: result 0 returned, rsp_err 0 (ALU default).
//  Reset mid-transaction: txn dropped, no response, state IDLE next cycle.
// CONFIGURATION
//  ALU_DIV0_CHECK_EN defined
//   - FLAG state present; rsp_err = alu_illegal for the txn
//  ALU_DIV0_CHECK_EN undefined
//   - FLAG removed; rsp_err tied 0; alu_illegal unused
// STRUCTURE
//  Shared package/header (cpu/defines.vh): ALU opcode `defines; FSM state encodings ARB_IDLE/EXEC/FLAG/RESP.
//  One sub-module, rr_arb2: 2-way round-robin picker, (valid[1:0], last) -> (gnt[1:0], id).
//  Remainder flat: FSM, operand/response registers.
// TESTING
//  1. req0 only, ADD 5+7 -> req_ready[0] same cycle; rsp_valid[0] cycle 3; data=12, zero=0, err=0.
//  2. Both valid after reset, SUB 9-9 / XOR 3^1 -> req0 served first (data 0, zero=1); then req1 (data 2).
//  3. Both valid continuously for 4 txns -> grants alternate 0,1,0,1; never two grants in a row to one port.
//  4. DIV a=10 b=0 -> macro on: err=1; macro off: err=0, rsp at cycle 2.
//  5. rsp_ready[0] low 5 cycles -> rsp_valid/data stable; req_ready both 0 throughout; IDLE after accept.
//  6. rst_n low during EXEC -> no rsp_valid ever; next ADD 1+1 completes normally with data 2.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU opcode encodings and arbiter FSM states shared by the ALU arbiter slice.
package alu_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam int OPW_DEF = 5;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5;
  localparam logic [4:0] OP_SRL = 5'd6;
  localparam logic [4:0] OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_MUL = 5'd10;
  localparam logic [4:0] OP_MULH = 5'd11;
  localparam logic [4:0] OP_DIV = 5'd12;
  localparam logic [4:0] OP_DIVU = 5'd13;
  localparam logic [4:0] OP_REM = 5'd14;
  localparam logic [4:0] OP_REMU = 5'd15;
  typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_FLAG, ARB_RESP} arb_state_t;
  function automatic logic is_div(input logic [4:0] op);
    return op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU;
  endfunction
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin picker; on a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       id
);
  always_comb begin
    id = &valid ? ~last : valid[1];
    gnt = |valid ? (id ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between EX stage (port 0) and address/branch unit (port 1), one txn in flight.
// ALU_DIV0_CHECK_EN adds the FLAG state that captures the ALU's registered divide-by-zero flag into rsp_err.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OPW-1:0]  req_op,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [OPW-1:0]    alu_op,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_res,
  input  logic              alu_zero,
  input  logic              alu_illegal
);
`ifdef ALU_DIV0_CHECK_EN
  localparam arb_state_t AFTER_EXEC = ARB_FLAG;
`else
  localparam arb_state_t AFTER_EXEC = ARB_RESP;
`endif
  arb_state_t state, state_nx;
  logic rr_last, id_q, gnt_id, zero_q, err_q, accept, done;
  logic [1:0] gnt;
  logic [OPW-1:0] op_q;
  logic [XLEN-1:0] a_q, b_q, data_q;
  rr_arb2 u_rr (
    .valid(req_valid),
    .last (rr_last),
    .gnt  (gnt),
    .id   (gnt_id)
  );
  assign req_ready = (rst_n && state == ARB_IDLE) ? gnt : 2'b00;
  assign accept = |req_ready;
  assign done = state == ARB_RESP && rsp_ready[id_q];
  assign rsp_valid = state == ARB_RESP ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err = err_q;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  always_ff @(posedge clk)
    if (!rst_n) state <= ARB_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: state_nx = accept ? ARB_EXEC : ARB_IDLE;
      ARB_EXEC: state_nx = AFTER_EXEC;
      ARB_FLAG: state_nx = ARB_RESP;
      ARB_RESP: state_nx = done ? ARB_IDLE : ARB_RESP;
      default:  state_nx = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
      id_q <= 1'b0;
      op_q <= OPW'(OP_ADD);
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        rr_last <= gnt_id;
        id_q <= gnt_id;
        op_q <= gnt_id ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
        a_q <= gnt_id ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
        b_q <= gnt_id ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
      end
      if (state == ARB_EXEC) begin
        data_q <= alu_res;
        zero_q <= alu_zero;
      end
    end
  end
`ifdef ALU_DIV0_CHECK_EN
  always_ff @(posedge clk)
    if (!rst_n) err_q <= 1'b0;
    else if (state == ARB_FLAG) err_q <= alu_illegal;
`else
  logic unused_illegal;
  assign err_q = 1'b0;
  assign unused_illegal = alu_illegal;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU; honours ALU_DIV0_CHECK_EN.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
`ifdef ALU_DIV0_CHECK_EN
  localparam int LAT = 3;
  localparam logic ERR = 1'b1;
`else
  localparam int LAT = 2;
  localparam logic ERR = 1'b0;
`endif
  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = 2'b11;
  logic [9:0] req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [31:0] rsp_data, alu_a, alu_b, alu_res;
  logic [4:0] alu_op;
  logic rsp_zero, rsp_err, alu_zero;
  logic alu_illegal = 1'b0;
  int checks = 0, passes = 0, lat;
  rsp_t exp_q[$];
  rsp_t got, e;

  alu_arbiter #(.XLEN(32), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .alu_zero(alu_zero), .alu_illegal(alu_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD) return a + b;
    if (op == OP_SUB) return a - b;
    if (op == OP_XOR) return a ^ b;
    if (op == OP_DIV || op == OP_DIVU) return b == 0 ? 32'hffff_ffff : a / b;
    return 32'd0;
  endfunction

  always_comb begin
    alu_res = alu_f(alu_op, alu_a, alu_b);
    alu_zero = alu_res == 32'd0;
  end

  always @(posedge clk) alu_illegal <= is_div(alu_op) && alu_b == 32'd0;

  task automatic set_req(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[p*5 +: 5] = op;
    req_a[p*32 +: 32] = a;
    req_b[p*32 +: 32] = b;
    req_valid[p] = 1'b1;
  endtask

  task automatic reset_dut;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts cycles from the calling negedge until a response shows; drops the listed requests after the first edge.
  task automatic wait_rsp(input logic [1:0] drop, output int n);
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) req_valid &= ~drop;
      n++;
    end while (rsp_valid == 2'b00 && n < 30);
  endtask

  task automatic take_rsp;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    got = {rsp_valid[1], rsp_data, rsp_zero, rsp_err};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 4'b0000) $display("FAIL reset_handshake got %b want 0000", {req_ready, rsp_valid});
    else passes++;
    checks++;
    if ({rsp_data, rsp_zero, rsp_err} !== 34'd0) $display("FAIL reset_rsp got %h want 0", {rsp_data, rsp_zero, rsp_err});
    else passes++;
    checks++;
    if ({alu_op, alu_a, alu_b} !== {OP_ADD, 64'd0}) $display("FAIL reset_alu got %h want %h", {alu_op, alu_a, alu_b}, {OP_ADD, 64'd0});
    else passes++;
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    set_req(0, OP_ADD, 32'd5, 32'd7);
    exp_q.push_back('{1'b0, 32'd12, 1'b0, 1'b0});
    #1;
    checks++;
    if (req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready);
    else passes++;
    wait_rsp(2'b01, lat);
    checks++;
    if (lat !== LAT) $display("FAIL single_latency got %0d want %0d", lat, LAT);
    else passes++;
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL single_rsp got %h want %h", got, e);
    else passes++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) $display("FAIL single_idle got %b want 00", rsp_valid);
    else passes++;
  endtask

  task automatic test_tie;
    reset_dut;
    set_req(0, OP_SUB, 32'd9, 32'd9);
    set_req(1, OP_XOR, 32'd3, 32'd1);
    exp_q.push_back('{1'b0, 32'd0, 1'b1, 1'b0});
    exp_q.push_back('{1'b1, 32'd2, 1'b0, 1'b0});
    #1;
    checks++;
    if (req_ready !== 2'b01) $display("FAIL tie_first_ready got %b want 01", req_ready);
    else passes++;
    wait_rsp(2'b01, lat);
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL tie_rsp0 got %h want %h", got, e);
    else passes++;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b10) $display("FAIL tie_second_ready got %b want 10", req_ready);
    else passes++;
    wait_rsp(2'b10, lat);
    checks++;
    if (lat !== LAT) $display("FAIL tie_latency got %0d want %0d", lat, LAT);
    else passes++;
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL tie_rsp1 got %h want %h", got, e);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int served[2];
    logic p;
    served = '{0, 0};
    set_req(0, OP_ADD, 32'd100, 32'd1);
    set_req(1, OP_ADD, 32'd200, 32'd2);
    exp_q.push_back('{1'b0, 32'd101, 1'b0, 1'b0});
    exp_q.push_back('{1'b1, 32'd202, 1'b0, 1'b0});
    exp_q.push_back('{1'b0, 32'd303, 1'b0, 1'b0});
    exp_q.push_back('{1'b1, 32'd404, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_rsp(2'b00, lat);
      take_rsp;
      checks++;
      if (got !== e) $display("FAIL b2b_%0d got %h want %h", k, got, e);
      else passes++;
      p = rsp_valid[1];
      served[p]++;
      if (served[p] == 1) set_req(int'(p), OP_ADD, p ? 32'd400 : 32'd300, p ? 32'd4 : 32'd3);
      else req_valid[p] = 1'b0;
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_div;
    set_req(0, OP_DIV, 32'd10, 32'd0);
    exp_q.push_back('{1'b0, 32'hffff_ffff, 1'b0, ERR});
    wait_rsp(2'b01, lat);
    checks++;
    if (lat !== LAT) $display("FAIL div0_latency got %0d want %0d", lat, LAT);
    else passes++;
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL div0_rsp got %h want %h", got, e);
    else passes++;
    @(negedge clk);
    set_req(0, 5'd31, 32'd6, 32'd7);
    exp_q.push_back('{1'b0, 32'd0, 1'b1, 1'b0});
    wait_rsp(2'b01, lat);
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL unknown_op_rsp got %h want %h", got, e);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    rsp_ready = 2'b10;
    set_req(0, OP_ADD, 32'd20, 32'd22);
    exp_q.push_back('{1'b0, 32'd42, 1'b0, 1'b0});
    wait_rsp(2'b01, lat);
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL bp_rsp got %h want %h", got, e);
    else passes++;
    set_req(1, OP_ADD, 32'd2, 32'd3);
    exp_q.push_back('{1'b1, 32'd5, 1'b0, 1'b0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_data, req_ready} !== {2'b01, 32'd42, 2'b00})
        $display("FAIL bp_hold_%0d got %h want %h", k, {rsp_valid, rsp_data, req_ready}, {2'b01, 32'd42, 2'b00});
      else passes++;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== 4'b0010) $display("FAIL bp_release got %b want 0010", {rsp_valid, req_ready});
    else passes++;
    wait_rsp(2'b10, lat);
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL bp_queued_rsp got %h want %h", got, e);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen;
    set_req(0, OP_ADD, 32'd4, 32'd4);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (alu_a !== 32'd0) $display("FAIL midrst_alu_a got %h want 0", alu_a);
    else passes++;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen |= |rsp_valid;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL midrst_no_rsp got %b want 0", seen);
    else passes++;
    set_req(0, OP_ADD, 32'd1, 32'd1);
    exp_q.push_back('{1'b0, 32'd2, 1'b0, 1'b0});
    wait_rsp(2'b01, lat);
    checks++;
    if (lat !== LAT) $display("FAIL midrst_latency got %0d want %0d", lat, LAT);
    else passes++;
    take_rsp;
    checks++;
    if (got !== e) $display("FAIL midrst_rsp got %h want %h", got, e);
    else passes++;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_back_to_back;
    test_div;
    test_backpressure;
    test_reset_mid;
    checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
